// File: rtl/uart_loopback_fifo.sv
// UART echo path: a configurable-frame receiver feeds a circular FIFO, and a transmitter drains it.
// Frames can be 5..8 data bits, none/odd/even parity and 1 or 2 stop bits; a hold input pauses transmission.
module uart_loopback_fifo #(
    parameter int UART_BPS   = 9600,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_ERR   = 1
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic                            rx,
    input  logic                            tx_hold,
    output logic                            tx,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            rx_parity_err,
    output logic                            rx_frame_err,
    output logic                            rx_overrun
);
    localparam int BIT_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = $clog2(BIT_CNT);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(BIT_CNT / 2);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity bit that makes the frame satisfy the configured odd/even rule.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    logic rx_sync1_r, rx_sync2_r, rx_dly_r;
    logic start_edge_s;
    state_t rx_state_r;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [2:0] rx_idx_r;
    logic rx_stop_idx_r, rx_stop_ok_r, rx_par_r;
    logic [DATA_BITS-1:0] rx_data_r, wr_data_r;
    logic rx_mid_s, rx_end_s, rx_perr_s, rx_ferr_s;
    logic perr_r, ferr_r, ovr_r, wr_req_r;

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [FCNT_W-1:0] count_r;
    logic accept_s, pop_s;

    state_t tx_state_r;
    logic [CNT_W-1:0] tx_cnt_r;
    logic [2:0] tx_idx_r;
    logic tx_stop_idx_r, tx_par_r, tx_r, tx_end_s;
    logic [DATA_BITS-1:0] tx_data_r;

    assign tx            = tx_r;
    assign fifo_count    = count_r;
    assign rx_parity_err = perr_r;
    assign rx_frame_err  = ferr_r;
    assign rx_overrun    = ovr_r;

    // Two-stage synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_sync1_r <= 1'b1;
            rx_sync2_r <= 1'b1;
            rx_dly_r   <= 1'b1;
        end else begin
            rx_sync1_r <= rx;
            rx_sync2_r <= rx_sync1_r;
            rx_dly_r   <= rx_sync2_r;
        end
    end

    // Decoded receive conditions, including the error verdict used at the last stop-bit sample.
    always_comb begin
        start_edge_s = rx_dly_r & ~rx_sync2_r;
        rx_mid_s     = (rx_cnt_r == CNT_MID);
        rx_end_s     = (rx_cnt_r == CNT_LAST);
        rx_ferr_s    = ~(rx_stop_ok_r & rx_sync2_r);
        if (PARITY != 0) begin
            rx_perr_s = (parity_bit(rx_data_r) != rx_par_r);
        end else begin
            rx_perr_s = 1'b0;
        end
    end

    // Receive FSM; error pulses and the FIFO write request are registered here.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_state_r    <= S_IDLE;
            rx_cnt_r      <= CNT_W'(0);
            rx_idx_r      <= 3'd0;
            rx_stop_idx_r <= 1'b0;
            rx_stop_ok_r  <= 1'b1;
            rx_par_r      <= 1'b0;
            rx_data_r     <= DATA_BITS'(0);
            wr_data_r     <= DATA_BITS'(0);
            wr_req_r      <= 1'b0;
            perr_r        <= 1'b0;
            ferr_r        <= 1'b0;
        end else begin
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
            wr_req_r <= 1'b0;
            rx_cnt_r <= rx_end_s ? CNT_W'(0) : rx_cnt_r + CNT_W'(1);
            case (rx_state_r)
                S_IDLE: begin
                    rx_cnt_r <= CNT_W'(0);
                    if (start_edge_s) rx_state_r <= S_START;
                end
                S_START: begin
                    if (rx_mid_s && rx_sync2_r) begin
                        rx_state_r <= S_IDLE;
                    end else if (rx_end_s) begin
                        rx_state_r <= S_DATA;
                        rx_idx_r   <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (rx_mid_s) rx_data_r <= {rx_sync2_r, rx_data_r[DATA_BITS-1:1]};
                    if (rx_end_s) begin
                        rx_idx_r <= rx_idx_r + 3'd1;
                        if (rx_idx_r == BIT_LAST) begin
                            rx_state_r    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            rx_stop_idx_r <= 1'b0;
                            rx_stop_ok_r  <= 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (rx_mid_s) rx_par_r <= rx_sync2_r;
                    if (rx_end_s) begin
                        rx_state_r    <= S_STOP;
                        rx_stop_idx_r <= 1'b0;
                        rx_stop_ok_r  <= 1'b1;
                    end
                end
                S_STOP: begin
                    // Leaving at mid-bit lets the next start edge be caught early.
                    if (rx_mid_s && rx_stop_idx_r == STOP_LAST) begin
                        rx_state_r <= S_IDLE;
                        perr_r     <= rx_perr_s;
                        ferr_r     <= rx_ferr_s;
                        wr_req_r   <= (DROP_ERR == 0) || !(rx_perr_s || rx_ferr_s);
                        wr_data_r  <= rx_data_r;
                    end else if (rx_mid_s) begin
                        rx_stop_ok_r <= rx_stop_ok_r & rx_sync2_r;
                    end
                    if (rx_end_s) rx_stop_idx_r <= rx_stop_idx_r + 1'b1;
                end
                default: rx_state_r <= S_IDLE;
            endcase
        end
    end

    // FIFO handshake: a full FIFO still accepts a word when a pop happens in the same cycle.
    always_comb begin
        pop_s    = (tx_state_r == S_IDLE) && (count_r != FCNT_W'(0)) && !tx_hold;
        accept_s = wr_req_r && ((count_r != FIFO_FULL) || pop_s);
        tx_end_s = (tx_cnt_r == CNT_LAST);
    end

    // FIFO pointers, occupancy and overrun pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= FCNT_W'(0);
            ovr_r    <= 1'b0;
        end else begin
            ovr_r <= wr_req_r && !accept_s;
            if (accept_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + FCNT_W'(1);
                2'b01:   count_r <= count_r - FCNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge sys_clk) begin
        if (accept_s) mem_r[wr_ptr_r] <= wr_data_r;
    end

    // Transmit FSM; tx is driven from a register so each bit lasts exactly BIT_CNT cycles.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_state_r    <= S_IDLE;
            tx_cnt_r      <= CNT_W'(0);
            tx_idx_r      <= 3'd0;
            tx_stop_idx_r <= 1'b0;
            tx_par_r      <= 1'b0;
            tx_data_r     <= DATA_BITS'(0);
            tx_r          <= 1'b1;
        end else begin
            tx_cnt_r <= tx_end_s ? CNT_W'(0) : tx_cnt_r + CNT_W'(1);
            case (tx_state_r)
                S_IDLE: begin
                    tx_cnt_r <= CNT_W'(0);
                    tx_r     <= 1'b1;
                    if (pop_s) begin
                        tx_data_r  <= mem_r[rd_ptr_r];
                        tx_par_r   <= parity_bit(mem_r[rd_ptr_r]);
                        tx_r       <= 1'b0;
                        tx_state_r <= S_START;
                    end
                end
                S_START: begin
                    if (tx_end_s) begin
                        tx_state_r <= S_DATA;
                        tx_idx_r   <= 3'd0;
                        tx_r       <= tx_data_r[0];
                    end
                end
                S_DATA: begin
                    if (tx_end_s) begin
                        tx_idx_r  <= tx_idx_r + 3'd1;
                        tx_data_r <= {1'b0, tx_data_r[DATA_BITS-1:1]};
                        if (tx_idx_r != BIT_LAST) begin
                            tx_r <= tx_data_r[1];
                        end else if (PARITY != 0) begin
                            tx_state_r <= S_PARITY;
                            tx_r       <= tx_par_r;
                        end else begin
                            tx_state_r    <= S_STOP;
                            tx_stop_idx_r <= 1'b0;
                            tx_r          <= 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tx_end_s) begin
                        tx_state_r    <= S_STOP;
                        tx_stop_idx_r <= 1'b0;
                        tx_r          <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_end_s) begin
                        tx_stop_idx_r <= tx_stop_idx_r + 1'b1;
                        if (tx_stop_idx_r == STOP_LAST) tx_state_r <= S_IDLE;
                    end
                end
                default: tx_state_r <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Directed bench for uart_loopback_fifo: five instances with different frame/FIFO settings,
// all at 16 clocks per bit, each stimulated and checked by its own scenario task.
module tb_uart_loopback_fifo;
    localparam int BIT = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rx_v, hold_v, tx_v, perr_v, ferr_v, ovr_v, fnz_v;
    logic [4:0] fc0, fc1, fc2, fc4;
    logic [2:0] fc3;
    int tests = 0;
    int fails = 0;
    longint cyc = 0;
    int perr_cnt [5];
    int ferr_cnt [5];
    int ovr_cnt [5];
    int txlow_cnt [5];
    int fnz_cnt [5];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb fnz_v = {fc4 != 5'd0, fc3 != 3'd0, fc2 != 5'd0, fc1 != 5'd0, fc0 != 5'd0};

    initial begin
        for (int i = 0; i < 5; i++) begin
            perr_cnt[i] = 0; ferr_cnt[i] = 0; ovr_cnt[i] = 0; txlow_cnt[i] = 0; fnz_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (perr_v[i]) perr_cnt[i] = perr_cnt[i] + 1;
            if (ferr_v[i]) ferr_cnt[i] = ferr_cnt[i] + 1;
            if (ovr_v[i]) ovr_cnt[i] = ovr_cnt[i] + 1;
            if (tx_v[i] === 1'b0) txlow_cnt[i] = txlow_cnt[i] + 1;
            if (fnz_v[i]) fnz_cnt[i] = fnz_cnt[i] + 1;
        end
    end

    uart_loopback_fifo #(.UART_BPS(10), .CLK_FREQ(160)) u0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_v[0]), .tx_hold(hold_v[0]), .tx(tx_v[0]),
        .fifo_count(fc0), .rx_parity_err(perr_v[0]), .rx_frame_err(ferr_v[0]), .rx_overrun(ovr_v[0]));
    uart_loopback_fifo #(.UART_BPS(10), .CLK_FREQ(160), .PARITY(2)) u1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_v[1]), .tx_hold(hold_v[1]), .tx(tx_v[1]),
        .fifo_count(fc1), .rx_parity_err(perr_v[1]), .rx_frame_err(ferr_v[1]), .rx_overrun(ovr_v[1]));
    uart_loopback_fifo #(.UART_BPS(10), .CLK_FREQ(160), .PARITY(2), .DROP_ERR(0)) u2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_v[2]), .tx_hold(hold_v[2]), .tx(tx_v[2]),
        .fifo_count(fc2), .rx_parity_err(perr_v[2]), .rx_frame_err(ferr_v[2]), .rx_overrun(ovr_v[2]));
    uart_loopback_fifo #(.UART_BPS(10), .CLK_FREQ(160), .FIFO_DEPTH(4)) u3 (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_v[3]), .tx_hold(hold_v[3]), .tx(tx_v[3]),
        .fifo_count(fc3), .rx_parity_err(perr_v[3]), .rx_frame_err(ferr_v[3]), .rx_overrun(ovr_v[3]));
    uart_loopback_fifo #(.UART_BPS(10), .CLK_FREQ(160), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u4 (
        .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_v[4]), .tx_hold(hold_v[4]), .tx(tx_v[4]),
        .fifo_count(fc4), .rx_parity_err(perr_v[4]), .rx_frame_err(ferr_v[4]), .rx_overrun(ovr_v[4]));

    // Expected line bits of one frame, index 0 = start bit.
    function automatic logic [11:0] frame_bits(input logic [7:0] d, input int nd, input int np,
                                               input logic pbit, input int ns);
        logic [11:0] r;
        int n;
        r = 12'h000;
        n = 1;
        for (int i = 0; i < nd; i++) begin r[n] = d[i]; n++; end
        if (np != 0) begin r[n] = pbit; n++; end
        for (int i = 0; i < ns; i++) begin r[n] = 1'b1; n++; end
        return r;
    endfunction

    task automatic drive_bit(input logic [4:0] mask, input logic v);
        @(negedge clk);
        if (v) rx_v = rx_v | mask;
        else rx_v = rx_v & ~mask;
        repeat (BIT - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [4:0] mask, input logic [7:0] d, input int nd, input int np,
                              input logic pbit, input int ns, input logic sbit);
        drive_bit(mask, 1'b0);
        for (int i = 0; i < nd; i++) drive_bit(mask, d[i]);
        if (np != 0) drive_bit(mask, pbit);
        for (int i = 0; i < ns; i++) drive_bit(mask, sbit);
    endtask

    // Waits for a tx falling edge, then samples every cycle of nbits bits plus one idle cycle.
    task automatic capture(input int ch, input int nbits, output logic [11:0] bits,
                           output longint t_fall, output bit found, output bit stable);
        logic prev, first, s;
        found = 1'b0; stable = 1'b1; bits = 12'h000; t_fall = 0; first = 1'b0;
        prev = tx_v[ch];
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && tx_v[ch] === 1'b0) begin found = 1'b1; break; end
            prev = tx_v[ch];
        end
        if (found) begin
            t_fall = cyc;
            for (int k = 0; k < nbits; k++) begin
                for (int j = 0; j < BIT; j++) begin
                    if (k != 0 || j != 0) @(negedge clk);
                    s = tx_v[ch];
                    if (j == 0) first = s;
                    else if (s !== first) stable = 1'b0;
                    if (j == BIT / 2) bits[k] = s;
                end
            end
            @(negedge clk);
            if (tx_v[ch] !== 1'b1) stable = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if (tx_v !== 5'h1f) begin fails++; $display("FAIL reset_tx actual=%b required=11111", tx_v); end
        tests++; if (fc0 !== 5'd0 || fc3 !== 3'd0) begin fails++; $display("FAIL reset_count actual=%0d/%0d required=0", fc0, fc3); end
        tests++; if ((perr_v | ferr_v | ovr_v) !== 5'h00) begin fails++; $display("FAIL reset_pulses actual=%b required=00000", perr_v | ferr_v | ovr_v); end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_echo(input string tag);
        logic [11:0] bits; longint tf; bit found, stable;
        int p0, f0, z0;
        p0 = perr_cnt[0]; f0 = ferr_cnt[0]; z0 = fnz_cnt[0];
        fork
            send_frame(5'b00001, 8'h55, 8, 0, 1'b0, 1, 1'b1);
            capture(0, 10, bits, tf, found, stable);
        join
        repeat (4) @(negedge clk);
        tests++;
        if (!found) begin fails++; $display("FAIL %s_found actual=none required=frame", tag); end
        else begin
            tests++; if (bits[9:0] !== 10'b1010101010) begin fails++; $display("FAIL %s_bits actual=%b required=1010101010", tag, bits[9:0]); end
            tests++; if (!stable) begin fails++; $display("FAIL %s_timing actual=unstable required=16-cycle bits", tag); end
        end
        tests++; if (fnz_cnt[0] - z0 != 1) begin fails++; $display("FAIL %s_count_cycles actual=%0d required=1", tag, fnz_cnt[0] - z0); end
        tests++; if (fc0 !== 5'd0) begin fails++; $display("FAIL %s_count_end actual=%0d required=0", tag, fc0); end
        tests++; if (perr_cnt[0] != p0 || ferr_cnt[0] != f0) begin fails++; $display("FAIL %s_errs actual=%0d/%0d required=0/0", tag, perr_cnt[0] - p0, ferr_cnt[0] - f0); end
    endtask

    task automatic test_parity();
        logic [11:0] bits, exp; longint tf; bit found, stable;
        int p1, p2, l1, z1;
        p1 = perr_cnt[1]; p2 = perr_cnt[2]; l1 = txlow_cnt[1]; z1 = fnz_cnt[1];
        exp = frame_bits(8'hA3, 8, 1, 1'b0, 1);
        fork
            send_frame(5'b00110, 8'hA3, 8, 1, 1'b1, 1, 1'b1);
            capture(2, 11, bits, tf, found, stable);
        join
        repeat (4) @(negedge clk);
        tests++; if (perr_cnt[1] - p1 != 1) begin fails++; $display("FAIL par_drop_pulse actual=%0d required=1", perr_cnt[1] - p1); end
        tests++; if (txlow_cnt[1] != l1) begin fails++; $display("FAIL par_drop_noecho actual=%0d low cycles required=0", txlow_cnt[1] - l1); end
        tests++; if (fnz_cnt[1] != z1) begin fails++; $display("FAIL par_drop_count actual=%0d nonzero cycles required=0", fnz_cnt[1] - z1); end
        tests++; if (perr_cnt[2] - p2 != 1) begin fails++; $display("FAIL par_keep_pulse actual=%0d required=1", perr_cnt[2] - p2); end
        tests++;
        if (!found) begin fails++; $display("FAIL par_keep_found actual=none required=frame"); end
        else begin
            tests++; if (bits[10:0] !== exp[10:0]) begin fails++; $display("FAIL par_keep_bits actual=%b required=%b", bits[10:0], exp[10:0]); end
        end
    endtask

    task automatic test_frame_err();
        logic [11:0] bits, exp; longint tf; bit found, stable;
        int f0, l0;
        f0 = ferr_cnt[0]; l0 = txlow_cnt[0];
        send_frame(5'b00001, 8'h3C, 8, 0, 1'b0, 1, 1'b0);
        drive_bit(5'b00001, 1'b1);
        drive_bit(5'b00001, 1'b1);
        tests++; if (ferr_cnt[0] - f0 != 1) begin fails++; $display("FAIL ferr_pulse actual=%0d required=1", ferr_cnt[0] - f0); end
        tests++; if (txlow_cnt[0] != l0) begin fails++; $display("FAIL ferr_noecho actual=%0d low cycles required=0", txlow_cnt[0] - l0); end
        exp = frame_bits(8'h7E, 8, 0, 1'b0, 1);
        fork
            send_frame(5'b00001, 8'h7E, 8, 0, 1'b0, 1, 1'b1);
            capture(0, 10, bits, tf, found, stable);
        join
        tests++;
        if (!found) begin fails++; $display("FAIL ferr_next_found actual=none required=frame"); end
        else begin
            tests++; if (bits[9:0] !== exp[9:0]) begin fails++; $display("FAIL ferr_next_bits actual=%b required=%b", bits[9:0], exp[9:0]); end
        end
    endtask

    task automatic test_overrun();
        logic [11:0] bits, exp; longint tf, tprev; bit found, stable;
        int o3;
        o3 = ovr_cnt[3];
        hold_v[3] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            send_frame(5'b01000, 8'(i), 8, 0, 1'b0, 1, 1'b1);
            if (i >= 4) begin
                tests++; if (fc3 !== 3'd4) begin fails++; $display("FAIL ovr_count_b%0d actual=%0d required=4", i, fc3); end
                tests++; if (ovr_cnt[3] - o3 != i - 4) begin fails++; $display("FAIL ovr_pulses_b%0d actual=%0d required=%0d", i, ovr_cnt[3] - o3, i - 4); end
            end
        end
        hold_v[3] = 1'b0;
        tprev = 0;
        for (int i = 1; i <= 4; i++) begin
            capture(3, 10, bits, tf, found, stable);
            exp = frame_bits(8'(i), 8, 0, 1'b0, 1);
            tests++;
            if (!found) begin fails++; $display("FAIL ovr_echo%0d_found actual=none required=frame", i); end
            else begin
                tests++; if (bits[9:0] !== exp[9:0]) begin fails++; $display("FAIL ovr_echo%0d_bits actual=%b required=%b", i, bits[9:0], exp[9:0]); end
                if (i > 1) begin
                    tests++; if (tf - tprev != 161) begin fails++; $display("FAIL ovr_gap%0d actual=%0d required=161", i, tf - tprev); end
                end
            end
            tprev = tf;
        end
        tests++; if (fc3 !== 3'd0) begin fails++; $display("FAIL ovr_drained actual=%0d required=0", fc3); end
    endtask

    task automatic test_7o2();
        logic [11:0] bits, exp; longint tf, tprev; bit found, stable;
        int p4, f4;
        p4 = perr_cnt[4]; f4 = ferr_cnt[4];
        exp = frame_bits(8'h41, 7, 1, 1'b1, 2);
        hold_v[4] = 1'b1;
        send_frame(5'b10000, 8'h41, 7, 1, 1'b1, 2, 1'b1);
        send_frame(5'b10000, 8'h41, 7, 1, 1'b1, 2, 1'b1);
        hold_v[4] = 1'b0;
        tprev = 0;
        for (int i = 0; i < 2; i++) begin
            capture(4, 11, bits, tf, found, stable);
            tests++;
            if (!found) begin fails++; $display("FAIL 7o2_found%0d actual=none required=frame", i); end
            else begin
                tests++; if (bits[10:0] !== exp[10:0]) begin fails++; $display("FAIL 7o2_bits%0d actual=%b required=%b", i, bits[10:0], exp[10:0]); end
                if (i == 1) begin
                    tests++; if (tf - tprev != 177) begin fails++; $display("FAIL 7o2_frame_len actual=%0d required=177", tf - tprev); end
                end
            end
            tprev = tf;
        end
        tests++; if (perr_cnt[4] != p4 || ferr_cnt[4] != f4) begin fails++; $display("FAIL 7o2_errs actual=%0d/%0d required=0/0", perr_cnt[4] - p4, ferr_cnt[4] - f4); end
    endtask

    task automatic test_reset_mid();
        hold_v[0] = 1'b1;
        send_frame(5'b00001, 8'h55, 8, 0, 1'b0, 1, 1'b1);
        send_frame(5'b00001, 8'h12, 8, 0, 1'b0, 1, 1'b1);
        tests++; if (fc0 !== 5'd2) begin fails++; $display("FAIL rstmid_prefill actual=%0d required=2", fc0); end
        hold_v[0] = 1'b0;
        fork
            send_frame(5'b00001, 8'h34, 8, 0, 1'b0, 1, 1'b1);
            begin
                repeat (40) @(negedge clk);
                tests++; if (tx_v[0] !== 1'b0) begin fails++; $display("FAIL rstmid_tx_busy actual=%b required=0", tx_v[0]); end
                #2 rst_n = 1'b0;
                #1;
                tests++; if (tx_v !== 5'h1f) begin fails++; $display("FAIL rstmid_tx actual=%b required=11111", tx_v); end
                tests++; if (fc0 !== 5'd0) begin fails++; $display("FAIL rstmid_count actual=%0d required=0", fc0); end
            end
        join
        tests++; if (tx_v[0] !== 1'b1) begin fails++; $display("FAIL rstmid_tx_held actual=%b required=1", tx_v[0]); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_echo("rst_echo");
    endtask

    task automatic test_glitch();
        int l0, f0, z0;
        l0 = txlow_cnt[0]; f0 = ferr_cnt[0]; z0 = fnz_cnt[0];
        @(negedge clk); rx_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        rx_v[0] = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        tests++; if (txlow_cnt[0] != l0) begin fails++; $display("FAIL glitch_noecho actual=%0d low cycles required=0", txlow_cnt[0] - l0); end
        tests++; if (ferr_cnt[0] != f0) begin fails++; $display("FAIL glitch_ferr actual=%0d required=0", ferr_cnt[0] - f0); end
        tests++; if (fnz_cnt[0] != z0) begin fails++; $display("FAIL glitch_count actual=%0d nonzero cycles required=0", fnz_cnt[0] - z0); end
        test_echo("glitch_echo");
    endtask

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        rx_v = 5'h1f;
        hold_v = 5'h00;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        test_reset();
        test_echo("echo55");
        test_parity();
        test_frame_err();
        test_overrun();
        test_7o2();
        test_reset_mid();
        test_glitch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_loopback_fifo.md
# uart_loopback_fifo

Parametrised UART echo block: receives serial frames on `rx`, buffers the received data words in an internal FIFO, and retransmits them on `tx`. It generalises the fixed 8N1 RX-to-TX loopback with configurable data width, parity, stop bits and FIFO depth. It adds error detection, overrun reporting and a transmit hold input. It sits at the board top level between the RS232 pins and is the bring-up/echo path for the serial link.

## Interface
- UART_BPS, 9600: baud rate.
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz. BIT_CNT = CLK_FREQ/UART_BPS, integer division (5208 at defaults).
- DATA_BITS, 8: data bits per frame, legal range 5..8, sent and received LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: number of entries, power of 2, minimum 2.
- DROP_ERR, 1: 1 = words with a parity or frame error are not written to the FIFO; 0 = they are written anyway.
- sys_clk  in  1  system clock; all logic is clocked on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, asynchronous to sys_clk, idles high.
- tx_hold  in  1  while high, TX does not start a new frame; a frame already in progress completes.
- tx  out  1  serial output, idles high.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of words currently in the FIFO.
- rx_parity_err  out  1  one-cycle pulse on a parity mismatch.
- rx_frame_err  out  1  one-cycle pulse when any sampled stop bit is 0.
- rx_overrun  out  1  one-cycle pulse when a good word is lost because the FIFO is full.

## Operation
- Reset values: tx=1, fifo_count=0, all pulse outputs 0, RX and TX in IDLE, FIFO pointers 0. Reset is asserted immediately and asynchronously, including in the middle of a frame. Any partial frame is discarded.
- RX input: `rx` passes through a 2-FF synchronizer plus one delay register. A start is detected as a falling edge (delayed=1, synced=0) while RX is in IDLE.
- RX FSM states: IDLE → START → DATA → PARITY (skipped when PARITY=0) → STOP → IDLE.
  - The baud counter runs 0..BIT_CNT-1 and is cleared on entry to START. Every sample is taken at count BIT_CNT/2.
  - START: if the sampled line is 1, the start is false; return to IDLE with no output.
  - DATA: shift in DATA_BITS samples, LSB first.
  - PARITY: compute XOR of the data bits. Odd parity requires XOR(data, parity bit)=1; even parity requires it to be 0.
  - STOP: sample STOP_BITS bits. At the mid-sample of the last stop bit, FSM returns to IDLE in the same cycle, so the next start edge can be caught half a bit early.
- RX completion cycle (mid-sample of the last stop bit):
  - Error pulses fire in this cycle. Both parity and frame errors may pulse together.
  - A write is requested if the frame had no error, or if DROP_ERR=0.
- FIFO: circular buffer of DATA_BITS-wide words.
  - A write is accepted if fifo_count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and rx_overrun pulses.
  - Pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves fifo_count unchanged.
- TX FSM states: IDLE → START → DATA → PARITY (skipped when PARITY=0) → STOP → IDLE.
  - In IDLE, when fifo_count>0 and tx_hold=0: pop the head word and latch it plus its parity; tx goes low on the next cycle.
  - Each bit is held for exactly BIT_CNT cycles. Parity bit values are as defined for RX. STOP sends STOP_BITS 1-bits.
  - After the final stop bit TX spends one cycle in IDLE before it can pop again.

## Timing
- Frame length on tx: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BIT_CNT cycles. Defaults: 10 × 5208 = 52080 cycles.
- RX latency, start edge on pin to FIFO write: 3 cycles of synchronizer/edge detection, then (1 + DATA_BITS + (PARITY≠0) + STOP_BITS − 1) × BIT_CNT + BIT_CNT/2 cycles.
- fifo_count updates on the cycle after a write or pop.
- Pop to tx falling edge: 1 cycle. Minimum gap between consecutive TX frames: 1 cycle of idle high.
- A tx_hold rise during a frame has no effect until TX returns to IDLE.

## Test plan
- Defaults, send 0x55 as 8N1 → identical frame on tx: start bit, bits 1,0,1,0,…, stop bit, each 5208 cycles long. fifo_count goes 0→1→0. No error pulses.
- PARITY=2, send 0xA3 with parity bit 1 (wrong, should be 0) → rx_parity_err pulses once, nothing is echoed, fifo_count stays 0. Repeat with DROP_ERR=0 → 0xA3 is echoed with correct parity bit 0.
- Send 0x3C with stop bit forced 0, then line high → rx_frame_err pulses; next valid byte 0x7E is echoed normally.
- FIFO_DEPTH=4, tx_hold=1, send 6 bytes 0x01..0x06 → fifo_count=4, rx_overrun pulses on bytes 5 and 6. Release tx_hold → 0x01..0x04 echoed in order with 1-cycle gaps.
- DATA_BITS=7, STOP_BITS=2, PARITY=1, send 0x41 → tx frame is 11 × BIT_CNT cycles long, parity bit = 1.
- Assert sys_rst_n low mid-way through a TX frame and mid-way through an RX frame → tx=1 immediately, fifo_count=0; after release, a clean 0x55 is echoed correctly. A 0.3-bit low glitch on rx is rejected as a false start.
